// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit between EX and the data RAM: one blocking op at a time,
// alignment/range checking, one-hot RAM size controls and a WB response.
module ysyx_22040125_lsu #(
   parameter logic [63:0] MEM_BASE  = 64'h0000_0000_8000_0000,
   parameter logic [63:0] MEM_BYTES = 64'd1600000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [31:0] ram_addr,
   output logic [63:0] wdata,
   output logic [5:0]  l_bhw,
   output logic [2:0]  s_bhwd,
   output logic        data_wen,
   output logic        data_ren,
   input  logic [63:0] rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_we,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_fault,
   output logic [63:0] resp_badaddr
);

   localparam logic [63:0] MEM_END = MEM_BASE + MEM_BYTES;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t      state;
   logic        pending;
   logic        op_load;
   logic [2:0]  op_funct3;
   logic [63:0] op_addr;
   logic [63:0] op_wdata;
   logic [4:0]  op_rd;

   logic        misaligned;
   logic        bad_funct3;
   logic        out_of_range;
   logic        fault;
   logic [5:0]  l_dec;
   logic [2:0]  s_dec;

   // Fault check and size decode, all from the latched op fields.
   always_comb begin
      misaligned = 1'b0;
      case (op_funct3[1:0])
         2'b01:   misaligned = op_addr[0];
         2'b10:   misaligned = |op_addr[1:0];
         2'b11:   misaligned = |op_addr[2:0];
         default: misaligned = 1'b0;
      endcase
      bad_funct3   = op_load ? (op_funct3 == 3'b111) : op_funct3[2];
      out_of_range = (op_addr < MEM_BASE) || (op_addr >= MEM_END);
      fault        = misaligned || bad_funct3 || out_of_range;

      l_dec = 6'b000000;
      case (op_funct3)
         3'b000:  l_dec = 6'b100000;
         3'b100:  l_dec = 6'b010000;
         3'b001:  l_dec = 6'b001000;
         3'b101:  l_dec = 6'b000100;
         3'b010:  l_dec = 6'b000010;
         3'b110:  l_dec = 6'b000001;
         default: l_dec = 6'b000000;
      endcase

      s_dec = 3'b000;
      case (op_funct3)
         3'b000:  s_dec = 3'b100;
         3'b001:  s_dec = 3'b010;
         3'b010:  s_dec = 3'b001;
         default: s_dec = 3'b000;
      endcase
   end

   // IDLE spends one cycle with 'pending' set so the fault check sees the
   // latched fields; the RAM strobes are single-cycle pulses in ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pending      <= 1'b0;
         op_load      <= 1'b0;
         op_funct3    <= 3'b000;
         op_addr      <= 64'd0;
         op_wdata     <= 64'd0;
         op_rd        <= 5'd0;
         req_ready    <= 1'b1;
         ram_addr     <= 32'd0;
         wdata        <= 64'd0;
         l_bhw        <= 6'd0;
         s_bhwd       <= 3'd0;
         data_wen     <= 1'b0;
         data_ren     <= 1'b0;
         resp_valid   <= 1'b0;
         resp_we      <= 1'b0;
         resp_data    <= 64'd0;
         resp_rd      <= 5'd0;
         resp_fault   <= 1'b0;
         resp_badaddr <= 64'd0;
      end else begin
         data_wen <= 1'b0;
         data_ren <= 1'b0;
         l_bhw    <= 6'd0;
         s_bhwd   <= 3'd0;
         case (state)
            IDLE: begin
               if (pending) begin
                  pending <= 1'b0;
                  if (fault) begin
                     state        <= RESP;
                     resp_valid   <= 1'b1;
                     resp_we      <= 1'b0;
                     resp_data    <= 64'd0;
                     resp_rd      <= op_rd;
                     resp_fault   <= 1'b1;
                     resp_badaddr <= op_addr;
                  end else begin
                     state    <= ACCESS;
                     ram_addr <= op_addr[31:0];
                     wdata    <= op_wdata;
                     if (op_load) begin
                        data_ren <= 1'b1;
                        l_bhw    <= l_dec;
                     end else begin
                        data_wen <= 1'b1;
                        s_bhwd   <= s_dec;
                     end
                  end
               end else if (req_valid && (req_load || req_store)) begin
                  pending   <= 1'b1;
                  req_ready <= 1'b0;
                  op_load   <= req_load;
                  op_funct3 <= req_funct3;
                  op_addr   <= req_addr;
                  op_wdata  <= req_wdata;
                  op_rd     <= req_rd;
               end
            end
            ACCESS: begin
               if (op_load) begin
                  state <= CAPTURE;
               end else begin
                  state        <= RESP;
                  resp_valid   <= 1'b1;
                  resp_we      <= 1'b0;
                  resp_data    <= 64'd0;
                  resp_rd      <= op_rd;
                  resp_fault   <= 1'b0;
                  resp_badaddr <= 64'd0;
               end
            end
            CAPTURE: begin
               state        <= RESP;
               resp_valid   <= 1'b1;
               resp_we      <= 1'b1;
               resp_data    <= rdata;
               resp_rd      <= op_rd;
               resp_fault   <= 1'b0;
               resp_badaddr <= 64'd0;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_we    <= 1'b0;
                  resp_fault <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Bench for ysyx_22040125_lsu: a transaction-level model predicts strobes and
// responses per cycle; directed ops add literal checks on key cycles.
module tb_ysyx_22040125_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_load = 1'b0;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic [4:0]  req_rd = 5'd0;
   logic [31:0] ram_addr;
   logic [63:0] wdata;
   logic [5:0]  l_bhw;
   logic [2:0]  s_bhwd;
   logic        data_wen;
   logic        data_ren;
   logic [63:0] rdata = 64'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic        resp_we;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_fault;
   logic [63:0] resp_badaddr;

   logic [63:0] ram_value = 64'd0;
   int          n_checks = 0;
   int          n_fail = 0;

   ysyx_22040125_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .ram_addr(ram_addr), .wdata(wdata),
      .l_bhw(l_bhw), .s_bhwd(s_bhwd),
      .data_wen(data_wen), .data_ren(data_ren), .rdata(rdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_we(resp_we), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_fault(resp_fault), .resp_badaddr(resp_badaddr)
   );

   always #5 clk = ~clk;

   // Registered RAM read port.
   always @(posedge clk) begin
      if (data_ren) rdata <= ram_value;
   end

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic logic op_fault(input logic ld, input logic [2:0] f3,
                                     input logic [63:0] a);
      longint unsigned size;
      size = 64'd1 << f3[1:0];
      if (ld ? (f3 == 3'b111) : (f3 >= 3'd4)) return 1'b1;
      if ((a % size) != 0) return 1'b1;
      if (a < 64'h8000_0000 || a >= 64'h8000_0000 + 64'd1600000) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [5:0] load_hot(input logic [2:0] f3);
      if (f3 == 3'b011) return 6'd0;
      return 6'd1 << (f3[2] ? (4 - 2 * f3[1:0]) : (5 - 2 * f3[1:0]));
   endfunction

   function automatic logic [2:0] store_hot(input logic [2:0] f3);
      if (f3 == 3'b011) return 3'd0;
      return 3'b100 >> f3[1:0];
   endfunction

   // Model: one active op, described by its accept cycle and the cycles at
   // which its RAM pulse and its response must appear.
   int          cyc = 0;
   logic        m_active = 1'b0;
   logic        m_load, m_fault;
   logic [2:0]  m_f3;
   logic [63:0] m_addr, m_wdata, m_ram;
   logic [4:0]  m_rd;
   int          m_acc, m_resp_cyc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0;
         m_active = 1'b0;
      end else begin
         cyc = cyc + 1;
         if (m_active && (cyc - 1) >= m_resp_cyc && resp_ready) begin
            m_active = 1'b0;
         end else if (!m_active && req_valid && (req_load || req_store)) begin
            m_active   = 1'b1;
            m_load     = req_load;
            m_f3       = req_funct3;
            m_addr     = req_addr;
            m_wdata    = req_wdata;
            m_rd       = req_rd;
            m_ram      = ram_value;
            m_acc      = cyc;
            m_fault    = op_fault(req_load, req_funct3, req_addr);
            m_resp_cyc = m_fault ? cyc + 1 : (req_load ? cyc + 3 : cyc + 2);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         logic strobe, rv;
         strobe = m_active && !m_fault && (cyc == m_acc + 1);
         rv     = m_active && (cyc >= m_resp_cyc);
         check_output("req_ready", req_ready, !m_active);
         check_output("data_ren", data_ren, strobe && m_load);
         check_output("data_wen", data_wen, strobe && !m_load);
         check_output("l_bhw", l_bhw, (strobe && m_load) ? load_hot(m_f3) : 6'd0);
         check_output("s_bhwd", s_bhwd, (strobe && !m_load) ? store_hot(m_f3) : 3'd0);
         if (strobe) begin
            check_output("ram_addr", ram_addr, m_addr[31:0]);
            if (!m_load) check_output("wdata", wdata, m_wdata);
         end
         check_output("resp_valid", resp_valid, rv);
         if (rv) begin
            check_output("resp_fault", resp_fault, m_fault);
            check_output("resp_we", resp_we, m_load && !m_fault);
            check_output("resp_data", resp_data, (m_load && !m_fault) ? m_ram : 64'd0);
            check_output("resp_rd", resp_rd, m_rd);
            check_output("resp_badaddr", resp_badaddr, m_fault ? m_addr : 64'd0);
         end
      end
   end

   // Presents one op for a single cycle; returns just after its accept edge.
   task automatic apply_stimulus(input logic ld, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 input logic [4:0] rd, input logic [63:0] ram);
      @(negedge clk);
      #1;
      ram_value  = ram;
      req_valid  = 1'b1;
      req_load   = ld;
      req_store  = !ld;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_rd     = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_store = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_active; i++) @(negedge clk);
      check_output("op_completes", m_active, 1'b0);
   endtask

   task automatic to_cycle(input int k);
      repeat (k + 1) @(negedge clk);
   endtask

   logic        t_ld[10]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [2:0]  t_f3[10]  = '{3'b010, 3'b101, 3'b001, 3'b010, 3'b100,
                              3'b111, 3'b000, 3'b011, 3'b110, 3'b011};
   logic [63:0] t_a[10]   = '{64'h8000_0100, 64'h8000_0102, 64'h8000_0202,
                              64'h8000_0204, 64'h8000_0000, 64'h8000_0010,
                              64'h8018_69FF, 64'h8018_69F8, 64'h8000_0000,
                              64'h8000_0008};

   initial begin
      repeat (2) @(negedge clk);
      check_output("reset_req_ready", req_ready, 1'b1);
      check_output("reset_resp_valid", resp_valid, 1'b0);
      check_output("reset_strobes", {data_ren, data_wen, l_bhw, s_bhwd}, 0);
      check_output("reset_ram_addr", ram_addr, 32'd0);
      #1 rst_n = 1'b1;

      // ld: pulse on the cycle after accept, result three cycles after accept.
      apply_stimulus(1'b1, 3'b011, 64'h8000_0010, 64'd0, 5'd7, 64'h1122334455667788);
      to_cycle(1);
      check_output("ld_ren", data_ren, 1'b1);
      check_output("ld_wen", data_wen, 1'b0);
      check_output("ld_bhw", l_bhw, 6'd0);
      repeat (2) @(negedge clk);
      check_output("ld_valid", resp_valid, 1'b1);
      check_output("ld_we", resp_we, 1'b1);
      check_output("ld_data", resp_data, 64'h1122334455667788);
      check_output("ld_rd", resp_rd, 5'd7);
      wait_idle();

      apply_stimulus(1'b0, 3'b000, 64'h8000_0003, 64'hAB, 5'd3, 64'd0);
      to_cycle(1);
      check_output("sb_wen", data_wen, 1'b1);
      check_output("sb_bhwd", s_bhwd, 3'b100);
      check_output("sb_addr", ram_addr, 32'h8000_0003);
      @(negedge clk);
      check_output("sb_wen_once", data_wen, 1'b0);
      check_output("sb_valid", resp_valid, 1'b1);
      check_output("sb_we", resp_we, 1'b0);
      wait_idle();

      apply_stimulus(1'b1, 3'b001, 64'h8000_0005, 64'd0, 5'd1, 64'd0);
      to_cycle(1);
      check_output("lh_fault", resp_fault, 1'b1);
      check_output("lh_badaddr", resp_badaddr, 64'h8000_0005);
      wait_idle();

      apply_stimulus(1'b1, 3'b010, 64'h7FFF_FFFC, 64'd0, 5'd2, 64'd0);
      to_cycle(1);
      check_output("lw_low_fault", resp_fault, 1'b1);
      wait_idle();
      apply_stimulus(1'b0, 3'b011, 64'h8018_6A00, 64'd5, 5'd2, 64'd0);
      to_cycle(1);
      check_output("sd_end_fault", resp_fault, 1'b1);
      check_output("sd_end_badaddr", resp_badaddr, 64'h8018_6A00);
      wait_idle();

      // Request with no type flag is dropped.
      @(negedge clk);
      #1 req_valid = 1'b1;
      @(negedge clk);
      #1 req_valid = 1'b0;

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(t_ld[i], t_f3[i], t_a[i], 64'h0123_4567_89AB_CDEF + i,
                        5'(i + 10), 64'hFEDC_0000_0000_0000 + i);
         wait_idle();
      end

      // Stalled response with a competing request held on the input.
      resp_ready = 1'b0;
      apply_stimulus(1'b1, 3'b100, 64'h8000_0021, 64'd0, 5'd9, 64'h0000_0000_0000_00F0);
      to_cycle(3);
      check_output("stall_valid", resp_valid, 1'b1);
      #1;
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b011; req_addr = 64'h8000_0008;
      repeat (5) @(negedge clk);
      #1;
      req_valid = 1'b0; req_store = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      check_output("stall_done_valid", resp_valid, 1'b0);
      check_output("stall_done_ready", req_ready, 1'b1);
      wait_idle();

      // Reset while the load sits in CAPTURE.
      apply_stimulus(1'b1, 3'b011, 64'h8000_0040, 64'd0, 5'd4, 64'h55);
      to_cycle(1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_resp_valid", resp_valid, 1'b0);
      check_output("rst_req_ready", req_ready, 1'b1);
      check_output("rst_strobes", {data_ren, data_wen}, 2'b00);
      @(negedge clk);
      #1 rst_n = 1'b1;
      apply_stimulus(1'b1, 3'b000, 64'h8000_0101, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FF80);
      to_cycle(3);
      check_output("post_rst_data", resp_data, 64'hFFFF_FFFF_FFFF_FF80);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
